// File: rtl/uart_cmd_master.sv
// UART command master: parses read/write frames from the UART receiver, runs one
// 8-bit bus cycle per frame and returns a status byte (plus read data) on a byte stream.
module uart_cmd_master #(
  parameter int unsigned BUS_TIMEOUT   = 255,
  parameter int unsigned FRAME_TIMEOUT = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  output logic       we_o,
  output logic       stb_o,
  input  logic       ack_i,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  input  logic       resp_rdy,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned BW = 16;
  localparam int unsigned FW = 20;
  localparam logic [7:0] OP_RD  = 8'h01;
  localparam logic [7:0] OP_WR  = 8'h02;
  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_BAD = 8'hEE;
  localparam logic [7:0] ST_TMO = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_ADR, S_DAT, S_BUS, S_RSP_STAT, S_RSP_DAT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    status_q, status_d;
  logic [BW-1:0] bus_cnt_q, bus_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [7:0]    resp_data_q, resp_data_d;
  logic          resp_valid_q, resp_valid_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      rdata_q      <= '0;
      status_q     <= '0;
      bus_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
      bus_cnt_q    <= bus_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    bus_cnt_d   = bus_cnt_q;
    frame_cnt_d = frame_cnt_q;
    stb_d       = stb_q;
    we_d        = we_q;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        frame_cnt_d = '0;
        if (rx_valid) begin
          if (rx_data == OP_RD || rx_data == OP_WR) begin
            op_d    = rx_data;
            state_d = S_ADR;
          end else begin
            status_d = ST_BAD;
            state_d  = S_RSP_STAT;
          end
        end
      end
      S_ADR, S_DAT: begin
        if (rx_valid) begin
          frame_cnt_d = '0;
          if (state_q == S_ADR) begin
            adr_d   = rx_data;
            state_d = (op_q == OP_WR) ? S_DAT : S_BUS;
          end else begin
            dat_d   = rx_data;
            state_d = S_BUS;
          end
        end else if (frame_cnt_q == FW'(FRAME_TIMEOUT - 1)) begin
          // Stalled partial frame is dropped silently so the parser resyncs
          frame_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end
      S_BUS: begin
        overrun_d = rx_valid;
        if (!stb_q) begin
          stb_d     = 1'b1;
          we_d      = (op_q == OP_WR);
          bus_cnt_d = '0;
        end else if (ack_i) begin
          stb_d    = 1'b0;
          we_d     = 1'b0;
          status_d = ST_OK;
          if (op_q == OP_RD) rdata_d = dat_i;
          state_d  = S_RSP_STAT;
        end else if (bus_cnt_q == BW'(BUS_TIMEOUT - 1)) begin
          stb_d    = 1'b0;
          we_d     = 1'b0;
          status_d = ST_TMO;
          state_d  = S_RSP_STAT;
        end else begin
          bus_cnt_d = bus_cnt_q + BW'(1);
        end
      end
      S_RSP_STAT: begin
        overrun_d = rx_valid;
        if (resp_valid_q && resp_rdy) begin
          state_d = (op_q == OP_RD && status_q == ST_OK) ? S_RSP_DAT : S_IDLE;
        end
      end
      S_RSP_DAT: begin
        overrun_d = rx_valid;
        if (resp_valid_q && resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    resp_valid_d = (state_d == S_RSP_STAT) || (state_d == S_RSP_DAT);
    resp_data_d  = '0;
    if (state_d == S_RSP_STAT) resp_data_d = status_d;
    else if (state_d == S_RSP_DAT) resp_data_d = rdata_d;
    busy_d = (state_d != S_IDLE);
  end

  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign we_o       = we_q;
  assign stb_o      = stb_q;
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: write/read frames, bus timeout, bad opcode,
// frame resync, overrun and async reset, with hand-computed expectations.
module tb_uart_cmd_master;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] adr_o, dat_o, resp_data;
  logic [7:0] dat_i = '0;
  logic       we_o, stb_o, resp_valid, busy, overrun;
  logic       ack_i = 1'b0;
  logic       resp_rdy = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_cmd_master #(.BUS_TIMEOUT(8), .FRAME_TIMEOUT(20)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .stb_o(stb_o),
    .ack_i(ack_i), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_rdy(resp_rdy), .busy(busy), .overrun(overrun)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Pulse ack with read data; the sampling edge ends the bus cycle
  task automatic do_ack(input logic [7:0] d);
    dat_i = d;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    dat_i = '0;
  endtask

  task automatic accept_byte(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(resp_data), 32'(exp));
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_rv0"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_busy0"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic bad;

    tick();
    tick();
    check_eq("rst_stb", 32'(stb_o), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rv", 32'(resp_valid), 32'd0);
    check_eq("rst_adr", 32'(adr_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Write frame, ack three cycles after strobe
    send_byte(8'h02);
    check_eq("wr_busy", 32'(busy), 32'd1);
    send_byte(8'h10);
    send_byte(8'hA5);
    check_eq("wr_stb_lat0", 32'(stb_o), 32'd0);
    tick();
    check_eq("wr_stb", 32'(stb_o), 32'd1);
    check_eq("wr_we", 32'(we_o), 32'd1);
    check_eq("wr_adr", 32'(adr_o), 32'h10);
    check_eq("wr_dat", 32'(dat_o), 32'hA5);
    tick();
    tick();
    check_eq("wr_stb_held", 32'(stb_o), 32'd1);
    check_eq("wr_adr_held", 32'(adr_o), 32'h10);
    do_ack(8'h00);
    check_eq("wr_stb_drop", 32'(stb_o), 32'd0);
    accept_byte("wr_stat", 8'h00);
    expect_idle("wr_end");

    // Read frame with downstream stall
    send_byte(8'h01);
    send_byte(8'h22);
    tick();
    check_eq("rd_stb", 32'(stb_o), 32'd1);
    check_eq("rd_we", 32'(we_o), 32'd0);
    check_eq("rd_adr", 32'(adr_o), 32'h22);
    do_ack(8'h5C);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_data !== 8'h00) bad = 1'b1;
    end
    check_eq("rd_stall_stable", 32'(bad), 32'd0);
    accept_byte("rd_stat", 8'h00);
    accept_byte("rd_data", 8'h5C);
    expect_idle("rd_end");

    // Bus timeout on a read: strobe high exactly BUS_TIMEOUT cycles
    send_byte(8'h01);
    send_byte(8'h33);
    tick();
    n = 0;
    while (stb_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check_eq("tmo_stb_cycles", 32'(n), 32'd8);
    accept_byte("tmo_stat", 8'hFF);
    expect_idle("tmo_end");

    // Bad opcode
    send_byte(8'h7F);
    accept_byte("bad_stat", 8'hEE);
    expect_idle("bad_end");

    // Stalled write frame: dropped after FRAME_TIMEOUT idle cycles
    send_byte(8'h02);
    send_byte(8'h10);
    bad = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (stb_o !== 1'b0 || resp_valid !== 1'b0) bad = 1'b1;
    end
    check_eq("resync_quiet", 32'(bad), 32'd0);
    check_eq("resync_busy_before", 32'(busy), 32'd1);
    tick();
    check_eq("resync_busy_after", 32'(busy), 32'd0);
    check_eq("resync_no_resp", 32'(resp_valid), 32'd0);

    // Normal read after resync
    send_byte(8'h01);
    send_byte(8'h00);
    tick();
    check_eq("rd2_stb", 32'(stb_o), 32'd1);
    check_eq("rd2_adr", 32'(adr_o), 32'h00);
    do_ack(8'h3C);
    accept_byte("rd2_stat", 8'h00);
    accept_byte("rd2_data", 8'h3C);
    expect_idle("rd2_end");

    // Overrun while strobe is high
    send_byte(8'h02);
    send_byte(8'h44);
    send_byte(8'h77);
    tick();
    check_eq("ovr_pre", 32'(overrun), 32'd0);
    send_byte(8'h99);
    check_eq("ovr_pulse", 32'(overrun), 32'd1);
    tick();
    check_eq("ovr_clear", 32'(overrun), 32'd0);
    check_eq("ovr_stb", 32'(stb_o), 32'd1);
    check_eq("ovr_adr", 32'(adr_o), 32'h44);
    check_eq("ovr_dat", 32'(dat_o), 32'h77);
    do_ack(8'h00);
    accept_byte("ovr_stat", 8'h00);
    expect_idle("ovr_end");

    // Async reset mid-bus
    send_byte(8'h01);
    send_byte(8'h55);
    tick();
    check_eq("ar_stb_pre", 32'(stb_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("ar_stb", 32'(stb_o), 32'd0);
    check_eq("ar_busy", 32'(busy), 32'd0);
    check_eq("ar_rv", 32'(resp_valid), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    send_byte(8'h02);
    send_byte(8'h66);
    send_byte(8'h88);
    tick();
    check_eq("ar_wr_stb", 32'(stb_o), 32'd1);
    check_eq("ar_wr_we", 32'(we_o), 32'd1);
    check_eq("ar_wr_adr", 32'(adr_o), 32'h66);
    check_eq("ar_wr_dat", 32'(dat_o), 32'h88);
    do_ack(8'h00);
    accept_byte("ar_wr_stat", 8'h00);
    expect_idle("ar_wr_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
